// File: rtl/adsr_bank.sv
// adsr_bank: round-robin multi-voice ADSR envelope generator sharing one patch.
// One channel is serviced per clock; every other channel holds its level, phase and accumulator.
module adsr_bank #(
  parameter int NUM_CHANNELS = 4,
  parameter int WIDTH = 24,
  parameter int FRAC = 8,
  localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_CHANNELS-1:0]       i_gate,
  input  logic                          i_retrigger,
  input  logic [WIDTH-1:0]              i_attack,
  input  logic [WIDTH-1:0]              i_decay,
  input  logic [WIDTH-1:0]              i_sustain,
  input  logic [WIDTH-1:0]              i_release,
  output logic [NUM_CHANNELS*WIDTH-1:0] o_envelope,
  output logic [3*NUM_CHANNELS-1:0]     o_adsr_state,
  output logic [NUM_CHANNELS-1:0]       o_running,
  output logic [IW-1:0]                 o_chan_idx
);
  localparam int AW = FRAC > 0 ? FRAC : 1;
  localparam int SW = FRAC + WIDTH + 1;
  localparam logic [WIDTH+1:0] MAX_EXT = {2'b00, {WIDTH{1'b1}}};
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_ATTACK = 3'd1, S_DECAY = 3'd2, S_SUSTAIN = 3'd3, S_RELEASE = 3'd4} state_t;
  logic [WIDTH-1:0]  r_env [NUM_CHANNELS];
  state_t            r_state [NUM_CHANNELS];
  logic [AW-1:0]     r_acc [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_gate_prev;
  logic [IW-1:0]     r_idx;
  logic [WIDTH-1:0]  w_env, w_env_n, w_rate;
  state_t            w_state, w_state_n;
  logic [AW-1:0]     w_acc, w_acc_n, w_lo;
  logic              w_gate, w_prev;
  logic [SW-1:0]     w_sum;
  logic [WIDTH:0]    w_d;
  logic [WIDTH+1:0]  w_up, w_floor;
  assign w_env   = r_env[r_idx];
  assign w_state = r_state[r_idx];
  assign w_acc   = r_acc[r_idx];
  assign w_gate  = i_gate[r_idx];
  assign w_prev  = r_gate_prev[r_idx];
  // Wide sums keep every comparison exact so the level never wraps past 0 or MAX.
  always_comb begin
    w_rate  = w_state == S_ATTACK ? i_attack : w_state == S_DECAY ? i_decay : i_release;
    w_sum   = (FRAC > 0 ? SW'(w_acc) : SW'(0)) + SW'(w_rate);
    w_d     = w_sum[SW-1:FRAC];
    w_lo    = FRAC > 0 ? w_sum[AW-1:0] : '0;
    w_up    = {2'b00, w_env} + {1'b0, w_d};
    w_floor = {2'b00, i_sustain} + {1'b0, w_d};
  end
  always_comb begin
    w_env_n   = w_env;
    w_state_n = w_state;
    w_acc_n   = w_acc;
    if (w_gate && !w_prev) begin
      w_state_n = S_ATTACK;
      w_acc_n   = '0;
      w_env_n   = i_retrigger ? '0 : w_env;
    end else if (!w_gate && w_prev && (w_state == S_ATTACK || w_state == S_DECAY || w_state == S_SUSTAIN)) begin
      w_state_n = S_RELEASE;
      w_acc_n   = '0;
    end else begin
      case (w_state)
        S_ATTACK: begin
          w_env_n   = w_up >= MAX_EXT ? {WIDTH{1'b1}} : w_up[WIDTH-1:0];
          w_state_n = w_up >= MAX_EXT ? S_DECAY : S_ATTACK;
          w_acc_n   = w_up >= MAX_EXT ? '0 : w_lo;
        end
        S_DECAY: begin
          w_env_n   = {2'b00, w_env} <= w_floor ? i_sustain : w_env - w_d[WIDTH-1:0];
          w_state_n = {2'b00, w_env} <= w_floor ? S_SUSTAIN : S_DECAY;
          w_acc_n   = {2'b00, w_env} <= w_floor ? '0 : w_lo;
        end
        S_SUSTAIN: w_env_n = i_sustain;
        S_RELEASE: begin
          w_env_n   = {1'b0, w_env} <= w_d ? '0 : w_env - w_d[WIDTH-1:0];
          w_state_n = {1'b0, w_env} <= w_d ? S_IDLE : S_RELEASE;
          w_acc_n   = {1'b0, w_env} <= w_d ? '0 : w_lo;
        end
        default: begin
          w_env_n   = '0;
          w_state_n = S_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_env[i]   <= '0;
        r_state[i] <= S_IDLE;
        r_acc[i]   <= '0;
      end
      r_gate_prev <= '0;
      r_idx       <= '0;
    end else begin
      r_env[r_idx]       <= w_env_n;
      r_state[r_idx]     <= w_state_n;
      r_acc[r_idx]       <= w_acc_n;
      r_gate_prev[r_idx] <= w_gate;
      r_idx              <= r_idx == IW'(NUM_CHANNELS - 1) ? '0 : r_idx + 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign o_envelope[g*WIDTH +: WIDTH] = r_env[g];
    assign o_adsr_state[3*g +: 3]       = r_state[g];
    assign o_running[g]                 = r_state[g] != S_IDLE;
  end
  assign o_chan_idx = r_idx;
endmodule

// File: tb/tb_adsr_bank.sv
// tb_adsr_bank: two instances (FRAC=0 and FRAC=8) on shared stimulus, checked every cycle
// against an integer envelope model plus directed literal expectations.
module tb_adsr_bank;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, retrig = 1;
  logic [3:0] gate = 0;
  logic [7:0] att = 0, dec = 0, sus = 0, rel = 0;
  logic [31:0] env0, env8;
  logic [11:0] st0, st8;
  logic [3:0] run0, run8;
  logic [1:0] idx0, idx8;
  int total = 0, bad = 0;
  int m_env [2][N], m_st [2][N], m_acc [2][N], m_prev [2][N];
  int m_idx = 0;
  bit m_valid = 0;
  always #5 clk = ~clk;
  adsr_bank #(.NUM_CHANNELS(4), .WIDTH(8), .FRAC(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_gate(gate), .i_retrigger(retrig),
    .i_attack(att), .i_decay(dec), .i_sustain(sus), .i_release(rel),
    .o_envelope(env0), .o_adsr_state(st0), .o_running(run0), .o_chan_idx(idx0));
  adsr_bank #(.NUM_CHANNELS(4), .WIDTH(8), .FRAC(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_gate(gate), .i_retrigger(retrig),
    .i_attack(att), .i_decay(dec), .i_sustain(sus), .i_release(rel),
    .o_envelope(env8), .o_adsr_state(st8), .o_running(run8), .o_chan_idx(idx8));
  task automatic svc(int f, int k);
    int sh, sum, d, g;
    sh = f ? 8 : 0;
    g = int'(gate[k]);
    if (g == 1 && m_prev[f][k] == 0) begin
      m_st[f][k] = 1;
      m_acc[f][k] = 0;
      if (retrig) m_env[f][k] = 0;
    end else if (g == 0 && m_prev[f][k] == 1 && m_st[f][k] >= 1 && m_st[f][k] <= 3) begin
      m_st[f][k] = 4;
      m_acc[f][k] = 0;
    end else begin
      case (m_st[f][k])
        1: begin
          sum = m_acc[f][k] + int'(att);
          d = sum >> sh;
          if (m_env[f][k] + d >= 255) begin m_env[f][k] = 255; m_st[f][k] = 2; m_acc[f][k] = 0; end
          else begin m_env[f][k] += d; m_acc[f][k] = sum % (1 << sh); end
        end
        2: begin
          sum = m_acc[f][k] + int'(dec);
          d = sum >> sh;
          if (m_env[f][k] <= int'(sus) + d) begin m_env[f][k] = int'(sus); m_st[f][k] = 3; m_acc[f][k] = 0; end
          else begin m_env[f][k] -= d; m_acc[f][k] = sum % (1 << sh); end
        end
        3: m_env[f][k] = int'(sus);
        4: begin
          sum = m_acc[f][k] + int'(rel);
          d = sum >> sh;
          if (m_env[f][k] <= d) begin m_env[f][k] = 0; m_st[f][k] = 0; m_acc[f][k] = 0; end
          else begin m_env[f][k] -= d; m_acc[f][k] = sum % (1 << sh); end
        end
        default: ;
      endcase
    end
    m_prev[f][k] = g;
  endtask
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      for (int f = 0; f < 2; f++)
        for (int k = 0; k < N; k++) begin
          m_env[f][k] = 0; m_st[f][k] = 0; m_acc[f][k] = 0; m_prev[f][k] = 0;
        end
      m_idx = 0;
    end else begin
      svc(0, m_idx);
      svc(1, m_idx);
      m_idx = (m_idx + 1) % N;
    end
    m_valid = 1;
  end
  initial forever begin : compare
    logic [49:0] got, exp;
    logic [31:0] xe;
    logic [11:0] xs;
    logic [3:0] xr;
    @(negedge clk);
    if (m_valid) begin
      for (int f = 0; f < 2; f++) begin
        for (int k = 0; k < N; k++) begin
          xe[k*8 +: 8] = 8'(m_env[f][k]);
          xs[3*k +: 3] = 3'(m_st[f][k]);
          xr[k] = m_st[f][k] != 0;
        end
        exp = {xe, xs, xr, 2'(m_idx)};
        got = f ? {env8, st8, run8, idx8} : {env0, st0, run0, idx0};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL model dut%0d t=%0t got=%h exp=%h", f ? 8 : 0, $time, got, exp);
        end
      end
    end
  end
  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic wait_slot(int k);
    bit hit = 0;
    for (int i = 0; i < 16 && !hit; i++) begin
      @(negedge clk);
      hit = int'(idx0) == (k + 1) % N;
    end
    if (!hit) chk("wait_slot timeout", 0, 1);
  endtask
  function automatic int e0(int k); return int'(env0[k*8 +: 8]); endfunction
  function automatic int s0(int k); return int'(st0[3*k +: 3]); endfunction
  initial begin
    int t2[8] = '{64, 128, 192, 255, 239, 223, 207, 200};
    int t3[3] = '{200, 100, 0};
    int t5[6] = '{0, 1, 1, 2, 2, 3};
    gate = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset env", int'(env0), 0);
    chk("reset state", int'(st0), 0);
    chk("reset run", int'(run0), 0);
    chk("reset idx", int'(idx0), 0);
    rst_n = 1;
    @(negedge clk);
    chk("t1 state0", s0(0), 1);
    chk("t1 run0", int'(run0[0]), 1);
    chk("t1 idx", int'(idx0), 1);
    gate = 0;
    repeat (12) @(negedge clk);
    chk("t1 all idle", int'({run0, run8}), 0);
    att = 64; dec = 16; sus = 200; rel = 100;
    gate[0] = 1;
    wait_slot(0);
    chk("t2 rise env", e0(0), 0);
    chk("t2 rise state", s0(0), 1);
    foreach (t2[i]) begin
      wait_slot(0);
      chk("t2 env", e0(0), t2[i]);
    end
    chk("t2 sustain state", s0(0), 3);
    chk("t2 others zero", int'(env0[31:8]), 0);
    gate[0] = 0;
    foreach (t3[i]) begin
      wait_slot(0);
      chk("t3 env", e0(0), t3[i]);
    end
    chk("t3 idle state", s0(0), 0);
    chk("t3 run0", int'(run0[0]), 0);
    rel = 0;
    gate[1] = 1;
    repeat (3) wait_slot(1);
    chk("t4 attack env", e0(1), 128);
    gate[1] = 0;
    wait_slot(1);
    chk("t4 release env", e0(1), 128);
    chk("t4 release state", s0(1), 4);
    wait_slot(1);
    chk("t4 release stall", e0(1), 128);
    retrig = 0; gate[1] = 1;
    wait_slot(1);
    chk("t4 legato env", e0(1), 128);
    chk("t4 legato state", s0(1), 1);
    wait_slot(1);
    chk("t4 legato step", e0(1), 192);
    gate[1] = 0;
    wait_slot(1);
    chk("t4 release2 state", s0(1), 4);
    retrig = 1; gate[1] = 1;
    wait_slot(1);
    chk("t4 retrig env", e0(1), 0);
    chk("t4 retrig state", s0(1), 1);
    gate[1] = 0; rel = 100;
    repeat (2) wait_slot(1);
    chk("t4 idle", int'(run0[1]), 0);
    att = 128;
    gate[3] = 1;
    wait_slot(3);
    foreach (t5[i]) begin
      wait_slot(3);
      chk("t5 frac env", int'(env8[31:24]), t5[i]);
    end
    att = 255; sus = 255;
    gate[2] = 1;
    wait_slot(2);
    wait_slot(2);
    chk("smax attack env", e0(2), 255);
    chk("smax decay state", s0(2), 2);
    wait_slot(2);
    chk("smax sustain state", s0(2), 3);
    sus = 0;
    wait_slot(2);
    chk("s0 env", e0(2), 0);
    chk("s0 running", int'(run0[2]), 1);
    gate[2] = 0;
    repeat (2) @(negedge clk);
    gate[2] = 1;
    wait_slot(2);
    chk("t6 pulse ignored", s0(2), 3);
    att = 255; dec = 1; sus = 100;
    gate[0] = 1;
    repeat (3) wait_slot(0);
    chk("t6 decay env", e0(0), 254);
    chk("t6 decay state", s0(0), 2);
    rst_n = 0;
    @(negedge clk);
    chk("t6 reset env", int'(env0), 0);
    chk("t6 reset state", int'(st0), 0);
    chk("t6 reset env8", int'(env8), 0);
    rst_n = 1;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adsr_bank.md
Name: adsr_bank

Overview:
- Multi-voice ADSR envelope generator; the next generation of the single-voice envelope block.
- NUM_CHANNELS independent envelopes, WIDTH bits each, share one patch (Attack/Decay/Sustain/Release rates plus mode).
- Channels are time-multiplexed: one channel is serviced per clock in round-robin order. Sits between the per-voice gate logic and the voice amplitude multipliers.
- Adds behaviour the old block lacked: fully synchronous gate handling, release from any active phase, fractional rate accumulation, and a legato/retrigger mode.

Parameters:
- NUM_CHANNELS, 4, number of voices (>=1).
- WIDTH, 24, envelope and rate width; full scale MAX = 2^WIDTH-1.
- FRAC, 8, fractional bits in each channel's rate accumulator (0 allowed).

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset).
- Gate  in  NUM_CHANNELS  per-voice gate; bit k belongs to channel k.
- Retrigger  in  1  1: a gate rise restarts the envelope from 0. 0: legato, the attack starts from the current level.
- Attack, Decay, Release  in  WIDTH each  rate increments per service; 0 holds the level.
- Sustain  in  WIDTH  sustain level.
- Envelope  out  NUM_CHANNELS*WIDTH  packed levels; channel k occupies bits [k*WIDTH +: WIDTH].
- ADSRstate  out  3*NUM_CHANNELS  packed state codes; channel k occupies [3k +: 3].
- Running  out  NUM_CHANNELS  1 while the channel's state is not IDLE.
- ChanIdx  out  max(1,clog2(NUM_CHANNELS))  index of the channel being serviced this cycle.

Behaviour:
- Reset (Reset==0 at a clock edge):
  - All Envelope, ADSRstate, Running, ChanIdx, accumulators and stored previous gates become 0.
  - Reset overrides everything, including mid-envelope operation.
- ChanIdx counts 0..NUM_CHANNELS-1 and wraps to 0; it advances every cycle.
- Service of a channel:
  - Only channel k = ChanIdx updates in a given cycle; all other channels hold.
  - Results are visible on the outputs the cycle after service.
  - Each channel is serviced every NUM_CHANNELS cycles.
- Gate sampling:
  - Gate[k] is sampled only in channel k's slot and compared with the value stored at its previous service.
  - Pulses that do not span a service slot are ignored.
- State codes: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Priority within a service, highest first:
  - Rise (gate 1, previous 0): state ATTACK, acc=0, Running=1; env=0 if Retrigger==1, otherwise env unchanged. Applies from any state, including RELEASE and ATTACK.
  - Fall (gate 0, previous 1) while in ATTACK, DECAY or SUSTAIN: state RELEASE, acc=0, env unchanged.
  - Otherwise, per-state update, where sum = acc + rate (zero-extended, FRAC+WIDTH+1 bits) and d = sum>>FRAC:
    - IDLE: hold, env stays 0.
    - ATTACK (rate=Attack): if env+d >= MAX, set env=MAX, state DECAY, acc=0. Otherwise env+=d and acc = low FRAC bits of sum.
    - DECAY (rate=Decay): if env <= Sustain+d (computed without overflow), set env=Sustain, state SUSTAIN, acc=0. Otherwise env-=d and acc = low bits of sum.
    - SUSTAIN: env = Sustain each service, so live Sustain changes track.
    - RELEASE (rate=Release): if env <= d, set env=0, state IDLE, Running=0. Otherwise env-=d and acc = low bits of sum.
- Boundary cases:
  - Sustain==MAX: DECAY completes on its first service.
  - Sustain==0: SUSTAIN holds 0 with Running still 1.
  - Rate 0 stalls the phase indefinitely; a gate edge still exits it.
- No arithmetic wraps: env stays within [0, MAX] at all times.
- Gate high when reset deasserts: treated as a rise at the channel's first service.

Test Plan (WIDTH=8, NUM_CHANNELS=4, FRAC=0 unless noted):
1. Reset held 3 cycles with Gate=4'hF -> all outputs 0. After release, channel 0 enters ATTACK (state 1, Running[0]=1) the cycle after its first slot.
2. Attack=64, Decay=16, Sustain=200, Gate[0] rise -> Envelope[0] takes 64,128,192,255 on successive services, then 239,223,207,200 with state SUSTAIN(3). Other channels stay 0.
3. Ch0 in SUSTAIN, Release=100, Gate[0] fall -> 200,100,0, then state IDLE, Running[0]=0.
4. Gate[1] falls mid-attack at env=128 -> RELEASE starts from 128. Re-rise with Retrigger=0 -> ATTACK resumes from the current level. Same re-rise with Retrigger=1 -> env restarts at 0.
5. FRAC=8, Attack=128 -> env increments by 1 every second service of that channel.
6. Gate pulse on ch2 lasting 2 cycles outside slot 2 -> ignored. Reset asserted mid-decay -> that channel returns to 0/IDLE on the next edge.
